// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard/memory handshake and stage-control bundle for pipe_stall_ctrl
//   master: hazard unit / memory side (drives load_use, br_taken, dmem_req, dmem_ready)
//   slave : pipe_stall_ctrl (drives write enables, flushes, memwb_bubble, mem_timeout, stall_cnt)
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use;
    logic             br_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output load_use, br_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_bubble, mem_timeout, stall_cnt
    );

    modport slave (
        input  load_use, br_taken, dmem_req, dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_bubble, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller with memory-wait freeze and timeout abort
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : pipe_stall_ctrl_if.slave (hazard inputs in, stage enables/flushes/status out)
//   Optional macro PIPE_STALL_CNT_EN builds the saturating stall counter; otherwise stall_cnt is 0.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_stall_ctrl_if.slave   bus
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              freeze;

    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, memwb_bubble;

    // In MEM_WAIT the access is already outstanding, so dmem_req is not re-checked.
    always_comb begin
        freeze = 1'b0;
        if (state_q == RUN) begin
            freeze = bus.dmem_req && !bus.dmem_ready;
        end else begin
            freeze = !bus.dmem_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    // Abort the wait; the counter never wraps because this fires first.
                    state_d   = RUN;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            // Hazard inputs are ignored here and re-evaluated on the first non-freeze cycle.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (bus.br_taken) begin
            // Branch wins over load_use: the load-using instruction is squashed anyway.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (bus.load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.idex_write   = idex_write;
    assign bus.exmem_write  = exmem_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.mem_timeout  = timeout_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-low.
REQ-002 Parameter TIMEOUT SHALL have default 16 and gives the maximum number of MEM_WAIT cycles before the memory-timeout abort.
REQ-003 Parameter CNT_W SHALL have default 16 and gives the stall-counter width.
REQ-004 Port clk SHALL be input, 1 bit: rising-edge clock.
REQ-005 Port rst_n SHALL be input, 1 bit: synchronous reset, active-low.
REQ-006 Port load_use SHALL be input, 1 bit: load-use hazard from the hazard unit, active-high.
REQ-007 Port br_taken SHALL be input, 1 bit: branch or jump resolved taken in EX.
REQ-008 Port dmem_req SHALL be input, 1 bit: the MEM-stage instruction accesses data memory.
REQ-009 Port dmem_ready SHALL be input, 1 bit: data memory completes the access this cycle.
REQ-010 Outputs pc_write, ifid_write, idex_write and exmem_write SHALL each be 1 bit: stage register load enables.
REQ-011 Outputs ifid_flush and idex_flush SHALL each be 1 bit: zero the stage register (insert a bubble).
REQ-012 Output memwb_bubble SHALL be 1 bit: MEM/WB loads a bubble instead of MEM results.
REQ-013 Output mem_timeout SHALL be 1 bit: sticky flag indicating that a memory wait was aborted.
REQ-014 Output stall_cnt SHALL be CNT_W bits: count of cycles with pc_write=0.

Function
REQ-015 States SHALL be RUN and MEM_WAIT, held in a registered state.
REQ-016 Outputs SHALL be combinational from the state and the current inputs, giving zero-cycle hazard response.
REQ-017 Output priority SHALL be, highest first: memory freeze, then br_taken, then load_use, then normal.
REQ-018 Memory freeze: in RUN with dmem_req=1 and dmem_ready=0, or in MEM_WAIT with dmem_ready=0, the block SHALL drive all four write enables to 0, both flushes to 0 and memwb_bubble=1.
REQ-019 In RUN, the freeze condition SHALL set next state MEM_WAIT and clear the wait counter.
REQ-020 In MEM_WAIT with dmem_ready=0, the wait counter SHALL increment.
REQ-021 In MEM_WAIT, when the counter reaches TIMEOUT-1 with dmem_ready still 0, the block SHALL set mem_timeout=1, take next state RUN and apply freeze outputs that cycle.
REQ-022 In MEM_WAIT with dmem_ready=1, the cycle SHALL be evaluated as a RUN cycle (branch, load-use or normal rules) and the next state SHALL be RUN.
REQ-023 Branch rule: the block SHALL drive pc_write=1, ifid_flush=1, idex_flush=1, ifid_write=1, idex_write=1, exmem_write=1 and memwb_bubble=0.
REQ-024 br_taken SHALL override a simultaneous load_use, because the load-using instruction is squashed.
REQ-025 Load-use rule: the block SHALL drive pc_write=0, ifid_write=0, idex_flush=1, idex_write=1, exmem_write=1, ifid_flush=0 and memwb_bubble=0.
REQ-026 Normal rule: all write enables SHALL be 1, and both flushes and memwb_bubble SHALL be 0.
REQ-027 A flush SHALL take precedence over the write enable of the same register.
REQ-028 mem_timeout SHALL clear only on reset.
REQ-029 The wait counter SHALL be ceil(log2(TIMEOUT)) bits wide and SHALL never wrap, because the abort occurs first.
REQ-030 load_use and br_taken SHALL be ignored while freeze applies, and re-evaluated on the first non-freeze cycle.

Reset
REQ-031 While rst_n=0 at a clock edge, the next state SHALL be RUN, the wait counter 0, mem_timeout 0 and stall_cnt 0.
REQ-032 While rst_n=0, outputs SHALL be pc_write=ifid_write=idex_write=exmem_write=0, ifid_flush=idex_flush=1 and memwb_bubble=1, regardless of state.
REQ-033 A reset asserted in MEM_WAIT SHALL abandon the wait without setting mem_timeout.

Configuration
REQ-034 With macro PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 each non-reset cycle in which pc_write=0, and SHALL saturate at all-ones.
REQ-035 Without PIPE_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-036 Load-use: load_use=1 for 1 cycle in RUN -> pc_write=0, ifid_write=0 and idex_flush=1 that cycle, then normal; stall_cnt +1 (macro on).
REQ-037 Branch plus load-use: br_taken=1 and load_use=1 in the same cycle -> pc_write=1, ifid_flush=1, idex_flush=1; no stall; stall_cnt unchanged.
REQ-038 Memory wait: dmem_req=1 with dmem_ready low 3 cycles, then high -> 3 freeze cycles with memwb_bubble=1, then a normal cycle in which the state returns to RUN; stall_cnt +3.
REQ-039 Timeout: TIMEOUT=4, dmem_req=1, dmem_ready held 0 -> mem_timeout=1 after the 5th freeze cycle (RUN entry plus 4 MEM_WAIT cycles), state RUN; the flag persists until rst_n=0.
REQ-040 Reset mid-wait: rst_n=0 during the 2nd MEM_WAIT cycle -> next cycle state RUN, mem_timeout=0, stall_cnt=0, and flush outputs are 1 while rst_n=0.
REQ-041 Saturation: CNT_W=4 with 20 load-use cycles -> stall_cnt=15 and held; with the macro off, stall_cnt=0 throughout.
